// File: rtl/saturn_serial_tx.sv
// saturn_serial_tx: 8N1 serial transmitter for the bus controller's debug
// character stream. Characters are queued ahead of a START/DATA/STOP shifter.
// Build option: define SATURN_SERIAL_TX_FIFO_EN for a 16-entry queue;
// otherwise the queue is a single holding register.
module saturn_serial_tx #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic [7:0] i_char,
  input  logic       i_char_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_tx
);

`ifdef SATURN_SERIAL_TX_FIFO_EN
  localparam int unsigned Depth = 16;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [15:0] TimerLast = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            timer_last;
  logic            push, pop, full, drop;
  logic [7:0]      head;

  assign timer_last = (timer_q == TimerLast);

  // A pop happens whenever the shifter is ready for a new character.
  assign pop  = (count_q != '0) &&
                ((state_q == StIdle) || ((state_q == StStop) && timer_last));
  // Full only when no slot frees up on this edge.
  assign full = (count_q == CntFull) && !pop;
  assign push = i_clk_en && i_char_valid && !full;
  assign drop = i_clk_en && i_char_valid && full;

  assign o_ready    = !full;
  assign o_busy     = (state_q != StIdle) || (count_q != '0);
  assign o_overflow = overflow_q;

`ifdef SATURN_SERIAL_TX_FIFO_EN
  logic [7:0] mem_q [Depth];
  logic [3:0] wr_ptr_q, rd_ptr_q;

  // Queue pointers; 4-bit pointers wrap modulo 16 by overflow.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
    end
  end

  // Queue storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_char;
  end

  assign head = mem_q[rd_ptr_q];
`else
  logic [7:0] hold_q;

  // Single holding register; a same-edge pop reads the old value.
  always_ff @(posedge i_clk) begin
    if (push) hold_q <= i_char;
  end

  assign head = hold_q;
`endif

  // Occupancy count and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Frame FSM next-state and serial output.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    o_tx    = 1'b1;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        bit_d   = '0;
        if (pop) begin
          shift_d = head;
          state_d = StStart;
        end
      end
      StStart: begin
        o_tx = 1'b0;
        if (timer_last) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StData: begin
        o_tx = shift_q[0];
        if (timer_last) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StStop: begin
        if (timer_last) begin
          timer_d = '0;
          // Back-to-back frames: go straight to the next start bit.
          if (pop) begin
            shift_d = head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/saturn_serial_tx.md
SATURN_SERIAL_TX -- requirements
Module: saturn_serial_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 217: i_clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have port i_clk  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port i_clk_en  input  1: qualifies character capture only; the bit timer ignores it.
REQ-005 SHALL have port i_char  input  8: debug character from the bus controller's o_char_to_send.
REQ-006 SHALL have port i_char_valid  input  1: i_char is presented this cycle.
REQ-007 SHALL have port o_ready  output  1: a character can be accepted this cycle.
REQ-008 SHALL have port o_busy  output  1: a frame is in progress or characters are queued.
REQ-009 SHALL have port o_overflow  output  1: sticky flag, a character was dropped.
REQ-010 SHALL have port o_tx  output  1: serial line, 8N1, idles high.

Function
REQ-011 SHALL capture i_char on an edge with i_clk_en=1, i_char_valid=1 and o_ready=1.
REQ-012 SHALL drive o_ready = not full, where "full" is the queue at capacity with no pop on the same edge.
REQ-013 SHALL accept a push to a full queue when a pop occurs on the same edge; no data is lost.
REQ-014 SHALL drop a character offered while o_ready=0 and set o_overflow=1 until reset.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: o_tx=1; when the queue is non-empty, SHALL pop the head into the shift register, clear the bit timer and enter START.
REQ-017 START: o_tx=0 for BAUD_DIV cycles, then SHALL enter DATA with bit index 0.
REQ-018 DATA: o_tx=shift[0] (LSB first) for BAUD_DIV cycles per bit, then shift right; after bit 7, SHALL enter STOP.
REQ-019 STOP: o_tx=1 for BAUD_DIV cycles; at expiry, SHALL pop and enter START directly if the queue is non-empty (no idle gap), else enter IDLE.
REQ-020 SHALL make a frame exactly 10*BAUD_DIV cycles long; the bit timer counts 0..BAUD_DIV-1 and wraps.
REQ-021 Latency: for a character captured at edge N into an empty, idle block, o_tx SHALL fall after edge N+1.
REQ-022 SHALL drive o_busy = (state != IDLE) or (queue non-empty).
REQ-023 SHALL NOT truncate or restart a frame in progress when new captures or overflows occur.
REQ-024 Queue pointers SHALL wrap modulo depth, with an occupancy count of width log2(depth)+1.

Reset
REQ-025 While i_reset=1, SHALL hold o_tx=1, o_ready=1, o_busy=0, o_overflow=0, state IDLE, queue empty and timer 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (o_tx=1 asynchronously) and discard queued characters.
REQ-027 After reset release, the first capture SHALL behave per REQ-021.

Configuration
REQ-028 With SATURN_SERIAL_TX_FIFO_EN defined, the queue SHALL be a 16-entry FIFO (o_ready=0 only with 16 entries and no pop).
REQ-029 Without SATURN_SERIAL_TX_FIFO_EN, the queue SHALL be a single holding register (depth 1), with all other behaviour unchanged.

Verification (BAUD_DIV=4)
REQ-030 Reset, then push 0x41 once -> o_tx low 4 cycles from edge N+1, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, high 4 cycles; o_busy falls after 40 cycles.
REQ-031 Push 0x55 then 0xAA on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; o_overflow=0.
REQ-032 Hold i_char_valid=1 with i_clk_en=0 -> no capture, o_tx stays 1, o_busy=0.
REQ-033 FIFO_EN: push 18 characters back-to-back during frame 1 -> 16 queued plus 1 in flight, the 18th dropped, o_overflow=1; 17 frames emitted in order.
REQ-034 No FIFO_EN: push 3 characters back-to-back -> first transmitted, second held, third dropped, o_overflow=1.
REQ-035 Assert i_reset during DATA bit 3 -> o_tx=1 immediately, o_busy=0, o_overflow=0; a subsequent push yields a clean frame.
